// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_defs (package)
//  Purpose  : Shared encodings for the MIPS16 memory / write-back stage:
//             memory-op codes, the "no write" register index and the SRAM
//             sequencer state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_defs;

   localparam logic [1:0] MEM_LOAD  = 2'b01;
   localparam logic [1:0] MEM_STORE = 2'b10;
   localparam logic [1:0] MEM_NONE  = 2'b11;

   localparam logic [3:0] REG_NONE  = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_WAIT  = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4
   } sram_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl
//  Purpose  : Sequences one asynchronous-SRAM read or write per request.
//             Owns the access FSM, the wait counter, the latched address /
//             write data and all SRAM strobes (registered, glitch-free).
//  Ports    : clk, rst (async, active-low)
//             start_load / start_store : request, sampled only in IDLE
//             addr / wdata             : captured on request
//             busy                     : FSM not in IDLE (Moore)
//             done                     : read completes on the coming edge
//             ram_addr / ram_data_out  : latched address / write data
//             ram_data_oe, ram_en_n, ram_oe_n, ram_we_n : bus controls
//  Revision : 1.0  initial release
// ============================================================================
module sram_ctrl
   import cpu_defs::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_load,
   input  logic        start_store,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_data_out,
   output logic        ram_data_oe,
   output logic        ram_en_n,
   output logic        ram_oe_n,
   output logic        ram_we_n
);

   localparam logic [3:0] C_WAIT = WAIT_CYCLES[3:0];

   sram_state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        data_oe_q, data_oe_d;
   logic        en_n_q, en_n_d;
   logic        oe_n_q, oe_n_d;
   logic        we_n_q, we_n_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= 16'd0;
         wdata_q   <= 16'd0;
         data_oe_q <= 1'b0;
         en_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         data_oe_q <= data_oe_d;
         en_n_q    <= en_n_d;
         oe_n_q    <= oe_n_d;
         we_n_q    <= we_n_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      done    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_load) begin
               addr_d  = addr;
               cnt_d   = C_WAIT;
               state_d = ST_RD_WAIT;
            end else if (start_store) begin
               addr_d  = addr;
               wdata_d = wdata;
               state_d = ST_WR_SETUP;
            end
         end
         ST_RD_WAIT: begin
            // <= 1 rather than == 1 so an out-of-range count cannot hang
            if (cnt_q <= 4'd1) begin
               done    = 1'b1;
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_WR_SETUP: begin
            cnt_d   = C_WAIT;
            state_d = ST_WR_PULSE;
         end
         ST_WR_PULSE: begin
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_WR_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_WR_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
         end
      endcase

      // Strobes are decoded from the next state and registered, so each one
      // switches exactly on the edge that enters/leaves its phase.
      en_n_d    = (state_d == ST_IDLE);
      oe_n_d    = (state_d != ST_RD_WAIT);
      we_n_d    = (state_d != ST_WR_PULSE);
      data_oe_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                  (state_d == ST_WR_HOLD);
   end

   assign busy         = (state_q != ST_IDLE);
   assign ram_addr     = addr_q;
   assign ram_data_out = wdata_q;
   assign ram_data_oe  = data_oe_q;
   assign ram_en_n     = en_n_q;
   assign ram_oe_n     = oe_n_q;
   assign ram_we_n     = we_n_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Purpose  : MIPS16 memory-access / write-back stage. Accepts one op per
//             cycle while idle; ALU ops write back after one edge, loads and
//             stores go through sram_ctrl and stall the upstream pipeline.
//             Write-back port comes straight from flops for the decode
//             stage's falling-edge register-file write.
//  Ports    : clk, rst (async, active-low)
//             aluResult, storeData, controlMem, memToReg, writeReg : op in
//             stall                        : upstream must hold
//             writeBackReg, writeBackData  : register-file write (15 = none)
//             ramAddr, ramDataOut, ramDataIn, ramDataOe,
//             ramEN_n, ramOE_n, ramWE_n    : asynchronous SRAM interface
//  Revision : 1.0  initial release
// ============================================================================
module mem_wb_stage
   import cpu_defs::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] aluResult,
   input  logic [15:0] storeData,
   input  logic [1:0]  controlMem,
   input  logic        memToReg,
   input  logic [3:0]  writeReg,
   output logic        stall,
   output logic [3:0]  writeBackReg,
   output logic [15:0] writeBackData,
   output logic [17:0] ramAddr,
   output logic [15:0] ramDataOut,
   input  logic [15:0] ramDataIn,
   output logic        ramDataOe,
   output logic        ramEN_n,
   output logic        ramOE_n,
   output logic        ramWE_n
);

   logic        busy;
   logic        done;
   logic [15:0] mem_addr;
   logic        start_load;
   logic        start_store;
   logic        start_alu;

   logic [3:0]  wb_reg_q, wb_reg_d;
   logic [15:0] wb_data_q, wb_data_d;
   logic [3:0]  ld_reg_q, ld_reg_d;
   logic        ld_m2r_q, ld_m2r_d;

   // Accept happens only on edges where the sequencer is idle.
   assign start_load  = !busy && (controlMem == MEM_LOAD);
   assign start_store = !busy && (controlMem == MEM_STORE);
   assign start_alu   = !busy && !start_load && !start_store;

   sram_ctrl #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_sram_ctrl (
      .clk          (clk),
      .rst          (rst),
      .start_load   (start_load),
      .start_store  (start_store),
      .addr         (aluResult),
      .wdata        (storeData),
      .busy         (busy),
      .done         (done),
      .ram_addr     (mem_addr),
      .ram_data_out (ramDataOut),
      .ram_data_oe  (ramDataOe),
      .ram_en_n     (ramEN_n),
      .ram_oe_n     (ramOE_n),
      .ram_we_n     (ramWE_n)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_reg_q  <= REG_NONE;
         wb_data_q <= 16'd0;
         ld_reg_q  <= REG_NONE;
         ld_m2r_q  <= 1'b0;
      end else begin
         wb_reg_q  <= wb_reg_d;
         wb_data_q <= wb_data_d;
         ld_reg_q  <= ld_reg_d;
         ld_m2r_q  <= ld_m2r_d;
      end
   end

   always_comb begin
      ld_reg_d  = ld_reg_q;
      ld_m2r_d  = ld_m2r_q;
      wb_reg_d  = REG_NONE;   // any edge without a completion writes nothing
      wb_data_d = wb_data_q;

      if (start_load) begin
         ld_reg_d = writeReg;
         ld_m2r_d = memToReg;
      end

      if (done) begin
         wb_reg_d  = ld_reg_q;
         wb_data_d = ld_m2r_q ? mem_addr : ramDataIn;
      end else if (start_alu) begin
         wb_reg_d  = writeReg;
         wb_data_d = aluResult;
      end
   end

   assign stall         = busy;
   assign writeBackReg  = wb_reg_q;
   assign writeBackData = wb_data_q;
   assign ramAddr       = {2'b00, mem_addr};

endmodule
`default_nettype wire
